// File: rtl/bus_mux_n.sv
// bus_mux_n: registered N-slave interconnect for a 68k-style master.
// Window decode, transfer latching, ack/read return and bus-error generation.
module bus_mux_n #(
    parameter int NSLAVES = 4,
    parameter int AW = 32,
    parameter int DW = 16,
    parameter logic [NSLAVES*AW-1:0] BASE = {
        32'h0010_0200, 32'h0010_0100, 32'h0010_0000, 32'h0000_0000
    },
    parameter logic [NSLAVES*AW-1:0] MASK = {
        32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFF0_0000
    },
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         master_write,
    output logic [DW-1:0]         master_read,
    input  logic [AW-1:0]         master_addr,
    input  logic                  master_uds,
    input  logic                  master_lds,
    output logic                  master_ack,
    output logic                  master_berr,
    output logic [DW-1:0]         slave_write,
    output logic [AW-1:0]         slave_addr,
    output logic [NSLAVES-1:0]    slave_uds,
    output logic [NSLAVES-1:0]    slave_lds,
    input  logic [NSLAVES*DW-1:0] slave_read,
    input  logic [NSLAVES-1:0]    slave_ack
);

    localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [SW-1:0]   sel;
    logic [CW-1:0]   cnt;
    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [NSLAVES-1:0] hit_oh;
    logic            strobe;

    assign strobe = master_uds | master_lds;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((master_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit = 1'b1;
                hit_idx = SW'(i);
            end
        end
        hit_oh = NSLAVES'(1) << hit_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            master_read <= '0;
            master_ack  <= 1'b0;
            master_berr <= 1'b0;
            slave_write <= '0;
            slave_addr  <= '0;
            slave_uds   <= '0;
            slave_lds   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (strobe) begin
                        slave_addr  <= master_addr;
                        slave_write <= master_write;
                        sel         <= hit_idx;
                        cnt         <= '0;
                        if (hit) begin
                            slave_uds <= master_uds ? hit_oh : '0;
                            slave_lds <= master_lds ? hit_oh : '0;
                            state     <= ACTIVE;
                        end else begin
                            master_berr <= 1'b1;
                            state       <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (!strobe) begin
                        slave_uds <= '0;
                        slave_lds <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (slave_ack[sel]) begin
                        master_read <= slave_read[sel*DW +: DW];
                        master_ack  <= 1'b1;
                        slave_uds   <= '0;
                        slave_lds   <= '0;
                        cnt         <= '0;
                        state       <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        master_berr <= 1'b1;
                        slave_uds   <= '0;
                        slave_lds   <= '0;
                        cnt         <= '0;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!strobe) begin
                        master_ack <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ERR: begin
                    if (!strobe) begin
                        master_berr <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
